// File: rtl/synth_channel_sequencer_pkg.sv
// Shared types for the synthesizer channel sequencer.
// Holds the channelizer control word, which is reused as the sequencer's output
// control bus, and the sequencer FSM state encoding.
package synth_channel_sequencer_pkg;

    localparam int unsigned DATA_INDEX_W      = 8;
    localparam int unsigned TRANSFORM_INDEX_W = 16;

    // Control word accompanying each sample on the channelizer/synthesizer link
    typedef struct packed {
        logic                         valid;
        logic                         last;
        logic                         first;
        logic                         overflow;
        logic [DATA_INDEX_W-1:0]      data_index;
        logic [TRANSFORM_INDEX_W-1:0] transform_index;
    } channelizer_control_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EMIT = 2'd1,
        GAP  = 2'd2
    } synth_seq_state_t;

endpackage

// File: rtl/synth_channel_store.sv
// Per-channel IQ holding store with pending bits.
// Ports:
//   clk, rst_n         clock, async active-low reset
//   wr_valid_i         write strobe; wr_index_i selects channel, wr_data_i is {I,Q}
//   rd_clear_i         consuming read of rd_index_i this cycle (clears pending)
//   rd_index_i         channel being read
//   rd_data_c          combinational pre-write contents of rd_index_i
//   rd_pending_c       combinational pre-write pending bit of rd_index_i
//   err_overwrite_o    registered pulse: a write replaced an unconsumed sample
module synth_channel_store #(
    parameter int unsigned NUM_CHANNELS = 16,
    parameter int unsigned IDX_W        = 4,
    parameter int unsigned DATA_WIDTH   = 22
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         wr_valid_i,
    input  logic [IDX_W-1:0]             wr_index_i,
    input  logic signed [DATA_WIDTH-1:0] wr_data_i [2],
    input  logic                         rd_clear_i,
    input  logic [IDX_W-1:0]             rd_index_i,
    output logic signed [DATA_WIDTH-1:0] rd_data_c [2],
    output logic                         rd_pending_c,
    output logic                         err_overwrite_o
);

    logic signed [DATA_WIDTH-1:0] store_i_q [NUM_CHANNELS];
    logic signed [DATA_WIDTH-1:0] store_q_q [NUM_CHANNELS];
    logic [NUM_CHANNELS-1:0]      pending_q;
    logic [NUM_CHANNELS-1:0]      pending_d;
    logic                         err_overwrite_q;
    logic                         err_overwrite_d;
    logic                         collide_c;

    // Reads always see pre-write contents
    assign rd_data_c[0] = store_i_q[rd_index_i];
    assign rd_data_c[1] = store_q_q[rd_index_i];
    assign rd_pending_c = pending_q[rd_index_i];

    // A consuming read of the written channel absorbs the old sample, so no overwrite
    assign collide_c       = rd_clear_i && (rd_index_i == wr_index_i);
    assign err_overwrite_d = wr_valid_i && pending_q[wr_index_i] && !collide_c;

    // Clear on read first, then set on write so a colliding write leaves pending high
    always_comb begin
        pending_d = pending_q;
        if (rd_clear_i) begin
            pending_d[rd_index_i] = 1'b0;
        end
        if (wr_valid_i) begin
            pending_d[wr_index_i] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q       <= '0;
            err_overwrite_q <= 1'b0;
            for (int unsigned k = 0; k < NUM_CHANNELS; k++) begin
                store_i_q[k] <= '0;
                store_q_q[k] <= '0;
            end
        end else begin
            pending_q       <= pending_d;
            err_overwrite_q <= err_overwrite_d;
            if (wr_valid_i) begin
                store_i_q[wr_index_i] <= wr_data_i[0];
                store_q_q[wr_index_i] <= wr_data_i[1];
            end
        end
    end

    assign err_overwrite_o = err_overwrite_q;

endmodule

// File: rtl/synth_channel_sequencer.sv
// Transmit-side feeder for the synthesizer: collects sparse per-channel IQ writes
// and emits one sample per channel per frame as a TDM stream.
// Ports:
//   Clk, Rst_n       clock, async active-low reset
//   Enable           start/continue frame generation (sampled in IDLE and on the last channel)
//   Channel_enable   per-channel emit mask
//   Input_valid/Input_index/Input_data   channel write port, data {I,Q}
//   Output_ctrl/Output_data              registered TDM output stream
//   Error_overwrite  pulse: write replaced an unconsumed sample
//   Error_underflow  pulse: enabled channel emitted with no fresh sample
module synth_channel_sequencer
    import synth_channel_sequencer_pkg::*;
#(
    parameter int unsigned NUM_CHANNELS        = 16,
    parameter int unsigned CHANNEL_INDEX_WIDTH = $clog2(NUM_CHANNELS),
    parameter int unsigned DATA_WIDTH          = 22,
    parameter int unsigned SAMPLE_SPACING      = 2
) (
    input  logic                              Clk,
    input  logic                              Rst_n,
    input  logic                              Enable,
    input  logic [NUM_CHANNELS-1:0]           Channel_enable,
    input  logic                              Input_valid,
    input  logic [CHANNEL_INDEX_WIDTH-1:0]    Input_index,
    input  logic signed [DATA_WIDTH-1:0]      Input_data [2],
    output channelizer_control_t              Output_ctrl,
    output logic signed [DATA_WIDTH-1:0]      Output_data [2],
    output logic                              Error_overwrite,
    output logic                              Error_underflow
);

    localparam logic [CHANNEL_INDEX_WIDTH-1:0] LAST_CHAN =
        CHANNEL_INDEX_WIDTH'(NUM_CHANNELS - 1);
    localparam int unsigned SPACE_W = (SAMPLE_SPACING > 2) ? $clog2(SAMPLE_SPACING - 1) : 1;
    localparam logic [SPACE_W-1:0] GAP_LAST =
        SPACE_W'((SAMPLE_SPACING > 1) ? SAMPLE_SPACING - 2 : 0);
    localparam synth_seq_state_t AFTER_EMIT = (SAMPLE_SPACING == 1) ? EMIT : GAP;

    synth_seq_state_t                 state_q, state_d;
    logic [CHANNEL_INDEX_WIDTH-1:0]   chan_q, chan_d;
    logic [SPACE_W-1:0]               space_q, space_d;
    logic [TRANSFORM_INDEX_W-1:0]     frame_q, frame_d;

    channelizer_control_t             ctrl_q, ctrl_d;
    logic signed [DATA_WIDTH-1:0]     data_q [2];
    logic signed [DATA_WIDTH-1:0]     data_d [2];
    logic                             underflow_q, underflow_d;

    logic                             rd_clear_c;
    logic signed [DATA_WIDTH-1:0]     rd_data_c [2];
    logic                             rd_pending_c;
    logic                             err_overwrite;

    synth_channel_store #(
        .NUM_CHANNELS (NUM_CHANNELS),
        .IDX_W        (CHANNEL_INDEX_WIDTH),
        .DATA_WIDTH   (DATA_WIDTH)
    ) u_store (
        .clk             (Clk),
        .rst_n           (Rst_n),
        .wr_valid_i      (Input_valid),
        .wr_index_i      (Input_index),
        .wr_data_i       (Input_data),
        .rd_clear_i      (rd_clear_c),
        .rd_index_i      (chan_q),
        .rd_data_c       (rd_data_c),
        .rd_pending_c    (rd_pending_c),
        .err_overwrite_o (err_overwrite)
    );

    // Sequencer FSM: next state, counters and next output word
    always_comb begin
        state_d     = state_q;
        chan_d      = chan_q;
        space_d     = space_q;
        frame_d     = frame_q;
        ctrl_d      = '0;
        data_d[0]   = '0;
        data_d[1]   = '0;
        underflow_d = 1'b0;
        rd_clear_c  = 1'b0;

        case (state_q)
            IDLE: begin
                if (Enable) begin
                    state_d = EMIT;
                    chan_d  = '0;
                    space_d = '0;
                end
            end
            EMIT: begin
                ctrl_d.valid           = 1'b1;
                ctrl_d.last            = (chan_q == LAST_CHAN);
                ctrl_d.data_index      = DATA_INDEX_W'(chan_q);
                ctrl_d.transform_index = frame_q;
                // Masked channels emit zero and leave their pending bit alone
                if (Channel_enable[chan_q]) begin
                    rd_clear_c = 1'b1;
                    if (rd_pending_c) begin
                        data_d[0] = rd_data_c[0];
                        data_d[1] = rd_data_c[1];
                    end else begin
                        underflow_d = 1'b1;
                    end
                end
                space_d = '0;
                if (chan_q == LAST_CHAN) begin
                    chan_d = '0;
                    if (!Enable) begin
                        state_d = IDLE;
                    end else begin
                        frame_d = frame_q + TRANSFORM_INDEX_W'(1);
                        state_d = AFTER_EMIT;
                    end
                end else begin
                    chan_d  = chan_q + CHANNEL_INDEX_WIDTH'(1);
                    state_d = AFTER_EMIT;
                end
            end
            GAP: begin
                if (space_q == GAP_LAST) begin
                    state_d = EMIT;
                    space_d = '0;
                end else begin
                    space_d = space_q + SPACE_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, counters and output register
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q     <= IDLE;
            chan_q      <= '0;
            space_q     <= '0;
            frame_q     <= '0;
            ctrl_q      <= '0;
            data_q[0]   <= '0;
            data_q[1]   <= '0;
            underflow_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            chan_q      <= chan_d;
            space_q     <= space_d;
            frame_q     <= frame_d;
            ctrl_q      <= ctrl_d;
            data_q[0]   <= data_d[0];
            data_q[1]   <= data_d[1];
            underflow_q <= underflow_d;
        end
    end

    assign Output_ctrl     = ctrl_q;
    assign Output_data[0]  = data_q[0];
    assign Output_data[1]  = data_q[1];
    assign Error_underflow = underflow_q;
    assign Error_overwrite = err_overwrite;

endmodule
